// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    localparam int MIN_DATA_BITS = 5;

    function automatic logic [3:0] clamp_data_bits(input logic [3:0] cfg, input int max_bits);
        if (int'(cfg) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
        if (int'(cfg) > max_bits) return 4'(max_bits);
        return cfg;
    endfunction

    // 2'b11 is treated as "no parity", same as 2'b00.
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchroniser plus the two-sample history used for 2-of-3 majority voting.
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic sample_en,
    output logic rx_sync,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [1:0]             samp_q;
    logic [1:0]             samp_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = rx;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign rx_sync = sync_q[SYNC_STAGES-1];

    // Third vote sample is the live synchronised line at the decision tick.
    assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync) | (samp_q[0] & rx_sync);

    always_comb begin
        samp_d = samp_q;
        if (sample_en) begin
            samp_d = {samp_q[0], rx_sync};
        end
    end

    // Preset to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            samp_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
            samp_q <= samp_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver: oversampled, majority-voted, with
// parity/frame/break detection and a valid/ready output register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     rx,
    input  logic                     en,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [MAX_DATA_BITS-1:0] m_data,
    output logic                     m_parity_err,
    output logic                     m_frame_err,
    output logic                     m_break,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic                     busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int H  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] S_VOTE0 = CW'(H - 1);
    localparam logic [CW-1:0] S_VOTE1 = CW'(H);
    localparam logic [CW-1:0] S_DEC   = CW'(H + 1);
    localparam logic [CW-1:0] S_END   = CW'(OVERSAMPLE - 1);

    rx_state_e                state_q, state_d;
    logic [CW-1:0]            s_cnt_q, s_cnt_d;
    logic [3:0]               bit_cnt_q, bit_cnt_d;
    logic [3:0]               n_bits_q, n_bits_d;
    parity_e                  par_q, par_d;
    logic                     stop2_q, stop2_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_bit_q, par_bit_d;
    logic                     par_err_q, par_err_d;
    logic                     frame_err_q, frame_err_d;

    logic                     m_valid_q, m_valid_d;
    logic [MAX_DATA_BITS-1:0] m_data_q, m_data_d;
    logic                     m_parity_err_q, m_parity_err_d;
    logic                     m_frame_err_q, m_frame_err_d;
    logic                     m_break_q, m_break_d;
    logic                     overrun_q, overrun_d;

    logic rx_sync;
    logic vote;
    logic sample_en;
    logic in_frame;
    logic at_dec;
    logic at_end;
    logic last_data;
    logic last_stop;
    logic par_en;
    logic par_expect;
    logic is_break;
    logic emit;
    logic emit_frame_err;
    logic load;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .sample_en (sample_en),
        .rx_sync   (rx_sync),
        .vote      (vote)
    );

    assign in_frame   = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign at_dec     = tick && (s_cnt_q == S_DEC);
    assign at_end     = tick && (s_cnt_q == S_END);
    assign last_data  = (bit_cnt_q == n_bits_q - 4'd1);
    assign last_stop  = (bit_cnt_q == {3'b000, stop2_q});
    assign par_en     = (par_q != PAR_NONE);
    assign par_expect = (par_q == PAR_ODD) ? ~(^shift_q) : (^shift_q);
    // Break: all-zero character including parity, seen at the first stop bit.
    assign is_break   = (bit_cnt_q == 4'd0) && !vote && (shift_q == '0) &&
                        !(par_en && par_bit_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            s_cnt_q        <= '0;
            bit_cnt_q      <= '0;
            n_bits_q       <= 4'(MIN_DATA_BITS);
            par_q          <= PAR_NONE;
            stop2_q        <= 1'b0;
            shift_q        <= '0;
            par_bit_q      <= 1'b0;
            par_err_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_parity_err_q <= 1'b0;
            m_frame_err_q  <= 1'b0;
            m_break_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_cnt_q        <= s_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            n_bits_q       <= n_bits_d;
            par_q          <= par_d;
            stop2_q        <= stop2_d;
            shift_q        <= shift_d;
            par_bit_q      <= par_bit_d;
            par_err_q      <= par_err_d;
            frame_err_q    <= frame_err_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_parity_err_q <= m_parity_err_d;
            m_frame_err_q  <= m_frame_err_d;
            m_break_q      <= m_break_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            case (state_q)
                ST_IDLE:     if (!rx_sync) state_d = ST_START;
                ST_START: begin
                    if (at_dec && vote) state_d = ST_IDLE;
                    else if (at_end)    state_d = ST_DATA;
                end
                ST_DATA:     if (at_end && last_data) state_d = par_en ? ST_PARITY : ST_STOP;
                ST_PARITY:   if (at_end) state_d = ST_STOP;
                ST_STOP: begin
                    if (at_dec && is_break)       state_d = ST_BRK_WAIT;
                    else if (at_dec && last_stop) state_d = ST_IDLE;
                end
                ST_BRK_WAIT: if (rx_sync) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        sample_en      = tick && in_frame && ((s_cnt_q == S_VOTE0) || (s_cnt_q == S_VOTE1));
        emit           = en && (state_q == ST_STOP) && at_dec && (is_break || last_stop);
        emit_frame_err = is_break || frame_err_q || !vote;
    end

    always_comb begin
        s_cnt_d     = s_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        n_bits_d    = n_bits_q;
        par_d       = par_q;
        stop2_d     = stop2_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;

        if (tick && in_frame) begin
            s_cnt_d = at_end ? '0 : s_cnt_q + CW'(1);
        end
        if (state_d == ST_IDLE || state_d == ST_BRK_WAIT) begin
            s_cnt_d = '0;
        end

        // Frame format is captured once per frame; later cfg_* changes are ignored.
        if (state_q == ST_IDLE && state_d == ST_START) begin
            s_cnt_d     = '0;
            bit_cnt_d   = '0;
            n_bits_d    = clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
            par_d       = decode_parity(cfg_parity);
            stop2_d     = cfg_stop2;
            shift_d     = '0;
            par_bit_d   = 1'b0;
            par_err_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        if (state_q == ST_DATA) begin
            if (at_dec) begin
                for (int i = 0; i < MAX_DATA_BITS; i++) begin
                    if (bit_cnt_q == 4'(i)) shift_d[i] = vote;
                end
            end
            if (at_end) bit_cnt_d = last_data ? 4'd0 : bit_cnt_q + 4'd1;
        end

        if (state_q == ST_PARITY && at_dec) begin
            par_bit_d = vote;
            par_err_d = (vote != par_expect);
        end

        if (state_q == ST_STOP) begin
            if (at_dec) frame_err_d = frame_err_q | ~vote;
            if (at_end) bit_cnt_d = bit_cnt_q + 4'd1;
        end
    end

    // Load when empty or when the held word is leaving this cycle; otherwise drop and flag.
    always_comb begin
        load           = emit && (!m_valid_q || m_ready);
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        m_parity_err_d = m_parity_err_q;
        m_frame_err_d  = m_frame_err_q;
        m_break_d      = m_break_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (load) begin
            m_valid_d      = 1'b1;
            m_data_d       = shift_q;
            m_parity_err_d = par_err_q;
            m_frame_err_d  = emit_frame_err;
            m_break_d      = is_break;
        end
        overrun_d = (emit && !load) || (overrun_q && !overrun_clr);
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_parity_err = m_parity_err_q;
    assign m_frame_err  = m_frame_err_q;
    assign m_break      = m_break_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: table of frame formats plus hand-written corner sequences.
module tb_uart_rx_cfg;

    localparam int MAXB = 9;
    localparam int OS   = 16;

    logic            clk;
    logic            rst;
    logic            tick;
    logic            rx;
    logic            en;
    logic [3:0]      cfg_data_bits;
    logic [1:0]      cfg_parity;
    logic            cfg_stop2;
    logic            m_valid;
    logic            m_ready;
    logic [MAXB-1:0] m_data;
    logic            m_parity_err;
    logic            m_frame_err;
    logic            m_break;
    logic            overrun;
    logic            overrun_clr;
    logic            busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [MAXB-1:0] data;
        logic            perr;
        logic            ferr;
        logic            brk;
    } word_t;

    word_t words[$];

    typedef struct {
        logic [8:0] data;
        logic [3:0] cfg_bits;
        int         tx_bits;
        logic [1:0] par;
        logic       stop2;
        logic       flip;
        logic       stop_bad;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[10];

    uart_rx_cfg #(
        .MAX_DATA_BITS(MAXB),
        .OVERSAMPLE(OS),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .rx            (rx),
        .en            (en),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_parity_err  (m_parity_err),
        .m_frame_err   (m_frame_err),
        .m_break       (m_break),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) words.push_back({m_data, m_parity_err, m_frame_err, m_break});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; each bit lasts OS clocks; optional 1-clk spike at cycle 10 of one bit.
    task automatic send_bits(input logic [31:0] bits, input int len, input int spike_bit);
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < OS; c++) begin
                rx = (b == spike_bit && c == 10) ? ~bits[b] : bits[b];
                step(1);
            end
        end
        rx = 1'b1;
    endtask

    task automatic build(input vec_t v, output logic [31:0] bits, output int len);
        logic p;
        logic pb;
        bits = '1;
        bits[0] = 1'b0;
        len = 1;
        p = 1'b0;
        for (int i = 0; i < v.tx_bits; i++) begin
            bits[len] = v.data[i];
            p = p ^ v.data[i];
            len++;
        end
        if (v.par == 2'b01 || v.par == 2'b10) begin
            pb = (v.par == 2'b10) ? ~p : p;
            if (v.flip) pb = ~pb;
            bits[len] = pb;
            len++;
        end
        bits[len] = ~v.stop_bad;
        len++;
        if (v.stop2) begin
            bits[len] = 1'b1;
            len++;
        end
    endtask

    task automatic send_8n1(input logic [7:0] d);
        vec_t v;
        logic [31:0] bits;
        int len;
        v = '{data: {1'b0, d}, cfg_bits: 4'd8, tx_bits: 8, par: 2'b00, stop2: 1'b0, flip: 1'b0,
              stop_bad: 1'b0, exp_data: 9'h0, exp_perr: 1'b0, exp_ferr: 1'b0};
        build(v, bits, len);
        send_bits(bits, len, -1);
    endtask

    task automatic expect_word(input string name, input logic [8:0] d, input logic pe,
                               input logic fe, input logic br);
        word_t w;
        check({name, "_count"}, words.size(), 1);
        if (words.size() != 0) begin
            w = words.pop_front();
            check({name, "_data"}, 32'(w.data), 32'(d));
            check({name, "_perr"}, 32'(w.perr), 32'(pe));
            check({name, "_ferr"}, 32'(w.ferr), 32'(fe));
            check({name, "_brk"}, 32'(w.brk), 32'(br));
            $display("%s: data=0x%03h perr=%0d ferr=%0d brk=%0d", name, w.data, w.perr, w.ferr, w.brk);
        end
        words.delete();
    endtask

    initial begin
        logic [31:0] bits;
        int len;
        int n;

        vecs[0] = '{9'h0A5, 4'd8,  8, 2'b00, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{9'h041, 4'd7,  7, 2'b01, 1'b1, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0};
        vecs[2] = '{9'h041, 4'd7,  7, 2'b01, 1'b1, 1'b1, 1'b0, 9'h041, 1'b1, 1'b0};
        vecs[3] = '{9'h041, 4'd7,  7, 2'b10, 1'b0, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0};
        vecs[4] = '{9'h041, 4'd7,  7, 2'b10, 1'b0, 1'b1, 1'b0, 9'h041, 1'b1, 1'b0};
        vecs[5] = '{9'h1F5, 4'd5,  5, 2'b00, 1'b0, 1'b0, 1'b0, 9'h015, 1'b0, 1'b0};
        vecs[6] = '{9'h1A5, 4'd12, 9, 2'b00, 1'b0, 1'b0, 1'b0, 9'h1A5, 1'b0, 1'b0};
        vecs[7] = '{9'h00B, 4'd3,  5, 2'b00, 1'b0, 1'b0, 1'b0, 9'h00B, 1'b0, 1'b0};
        vecs[8] = '{9'h055, 4'd8,  8, 2'b00, 1'b0, 1'b0, 1'b1, 9'h055, 1'b0, 1'b1};
        vecs[9] = '{9'h00E, 4'd6,  6, 2'b11, 1'b0, 1'b0, 1'b0, 9'h00E, 1'b0, 1'b0};

        rst = 1'b1; tick = 1'b1; rx = 1'b1; en = 1'b1; m_ready = 1'b1; overrun_clr = 1'b0;
        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        step(3);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_flags", {29'd0, m_parity_err, m_frame_err, m_break}, 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step(4);

        for (int i = 0; i < 10; i++) begin
            cfg_data_bits = vecs[i].cfg_bits;
            cfg_parity    = vecs[i].par;
            cfg_stop2     = vecs[i].stop2;
            build(vecs[i], bits, len);
            send_bits(bits, len, -1);
            step(48);
            expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
        end

        // Latency: 3 clks (2 sync + idle detect) + 9 full bits + 10 clks to the stop decision = 157 edges.
        cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        fork
            send_8n1(8'hA5);
            begin
                n = 0;
                while (n < 400 && !m_valid) begin
                    step(1);
                    n++;
                end
                check("latency_edges", n, 157);
                step(1);
                check("valid_pulse_fall", 32'(m_valid), 0);
            end
        join
        step(32);
        expect_word("latency_word", 9'h0A5, 1'b0, 1'b0, 1'b0);

        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(2);
        check("glitch_busy_hi", 32'(busy), 1);
        step(20);
        check("glitch_busy_lo", 32'(busy), 0);
        check("glitch_no_word", words.size(), 0);
        $display("glitch: busy=%0d words=%0d", busy, words.size());

        build(vecs[0], bits, len);
        send_bits(bits, len, 4);
        step(48);
        expect_word("spike", 9'h0A5, 1'b0, 1'b0, 1'b0);

        rx = 1'b0;
        step(20 * OS);
        check("break_one_word", words.size(), 1);
        check("break_busy", 32'(busy), 1);
        rx = 1'b1;
        step(32);
        check("break_released", 32'(busy), 0);
        expect_word("break", 9'h000, 1'b0, 1'b1, 1'b1);
        send_8n1(8'h55);
        step(48);
        expect_word("after_break", 9'h055, 1'b0, 1'b0, 1'b0);

        m_ready = 1'b0;
        send_8n1(8'h11);
        step(32);
        send_8n1(8'h22);
        step(32);
        check("ovr_valid", 32'(m_valid), 1);
        check("ovr_data", 32'(m_data), 32'h11);
        check("ovr_set", 32'(overrun), 1);
        $display("overrun: data=0x%03h overrun=%0d", m_data, overrun);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 0);
        fork
            send_8n1(8'h33);
            begin
                step(156);
                overrun_clr = 1'b1;
                step(1);
                overrun_clr = 1'b0;
            end
        join
        step(32);
        check("ovr_set_wins", 32'(overrun), 1);
        check("ovr_data_kept", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        step(1);
        m_ready = 1'b0;
        step(1);
        expect_word("ovr_drain", 9'h011, 1'b0, 1'b0, 1'b0);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;

        send_8n1(8'h44);
        step(32);
        fork
            send_8n1(8'h66);
            begin
                step(156);
                m_ready = 1'b1;
                step(1);
                m_ready = 1'b0;
            end
        join
        step(32);
        check("same_cycle_no_ovr", 32'(overrun), 0);
        check("same_cycle_data", 32'(m_data), 32'h66);
        check("same_cycle_valid", 32'(m_valid), 1);
        expect_word("same_cycle_old", 9'h044, 1'b0, 1'b0, 1'b0);
        m_ready = 1'b1;
        step(2);
        expect_word("same_cycle_new", 9'h066, 1'b0, 1'b0, 1'b0);

        send_bits(32'h0, 4, -1);
        rst = 1'b1;
        step(2);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(m_valid), 0);
        check("midrst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        step(32);
        send_8n1(8'h3C);
        step(48);
        expect_word("after_rst", 9'h03C, 1'b0, 1'b0, 1'b0);

        m_ready = 1'b0;
        send_8n1(8'h5A);
        step(32);
        send_bits(32'h0, 4, -1);
        check("en_busy_before", 32'(busy), 1);
        en = 1'b0;
        step(1);
        check("en_off_busy", 32'(busy), 0);
        check("en_off_valid", 32'(m_valid), 1);
        check("en_off_data", 32'(m_data), 32'h5A);
        step(16);
        m_ready = 1'b1;
        step(2);
        expect_word("en_kept", 9'h05A, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step(16);
        send_8n1(8'h3C);
        step(48);
        expect_word("after_en", 9'h03C, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
